// File: rtl/tpu_pkg.sv
// Shared sizes and types for the tpu_mac_core slice.
package tpu_pkg;

  localparam int DATA_W         = 8;
  localparam int ELEM_W         = 16;
  localparam int DIM            = 2;
  localparam int WORD_W         = DIM * DIM * ELEM_W;
  localparam int BYTES_PER_WORD = 8;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef logic [ELEM_W-1:0] elem_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    SEL_A,
    SEL_B
  } sel_t;

endpackage

// File: rtl/tpu_byte_assembler.sv
// Edge-detects the byte strobe and packs bytes MSB-first into 64-bit words,
// pulsing o_word_done for one cycle after the eighth byte.
module tpu_byte_assembler
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_write_en,
  output logic              o_word_done,
  output word_t             o_word
);

  logic                       r_write_q;
  logic [CNT_W-1:0]           r_count;
  logic [WORD_W-DATA_W-1:0]   r_shift;
  word_t                      r_word;
  logic                       r_word_done;
  logic                       w_write_pulse;
  word_t                      w_next;

  assign w_write_pulse = i_write_en & ~r_write_q;
  // Only the first seven bytes need holding; the eighth completes the word.
  assign w_next        = {r_shift, i_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write_q   <= 1'b0;
      r_count     <= '0;
      r_shift     <= '0;
      r_word      <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_write_q   <= i_write_en;
      r_word_done <= 1'b0;
      if (w_write_pulse) begin
        r_shift <= w_next[WORD_W-DATA_W-1:0];
        if (r_count == CNT_W'(BYTES_PER_WORD - 1)) begin
          r_count     <= '0;
          r_word      <= w_next;
          r_word_done <= 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign o_word_done = r_word_done;
  assign o_word      = r_word;

endmodule

// File: rtl/tpu_mac_core.sv
// Byte-serial 2x2 matrix multiply-accumulate core (A word, then B word).
// Define TPU_ACC_SAT_EN to saturate accumulator elements instead of wrapping.
module tpu_mac_core
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_en,
  input  logic              acc_en,
  input  logic              clear,
  output logic              word_done,
  output logic              pair_ready,
  output logic [WORD_W-1:0] mult_out,
  output logic [WORD_W-1:0] acc_out
);

  sel_t  r_sel;
  word_t r_a;
  word_t r_b;
  word_t r_acc;
  logic  r_acc_q;
  logic  r_pair_ready;
  logic  w_word_done;
  word_t w_word;
  word_t w_mult;
  word_t w_acc_next;
  elem_t w_sum;
  logic  w_acc_pulse;

  function automatic elem_t accAdd(elem_t a, elem_t b);
`ifdef TPU_ACC_SAT_EN
    logic [ELEM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ELEM_W] ? '1 : s[ELEM_W-1:0];
`else
    return a + b;
`endif
  endfunction

  tpu_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .i_data     (data_in),
    .i_write_en (write_en),
    .o_word_done(w_word_done),
    .o_word     (w_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel        <= SEL_A;
      r_a          <= '0;
      r_b          <= '0;
      r_pair_ready <= 1'b0;
    end else begin
      r_pair_ready <= 1'b0;
      if (w_word_done) begin
        case (r_sel)
          SEL_A: begin
            r_a   <= w_word;
            r_sel <= SEL_B;
          end
          SEL_B: begin
            r_b          <= w_word;
            r_sel        <= SEL_A;
            r_pair_ready <= 1'b1;
          end
          default: r_sel <= SEL_A;
        endcase
      end
    end
  end

  // 16-bit operands keep the products and sums modulo 2^16 by construction.
  always_comb begin
    w_mult = '0;
    w_sum  = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        w_sum = '0;
        for (int k = 0; k < DIM; k++) begin
          w_sum = w_sum + r_a[(r*DIM+k)*ELEM_W +: ELEM_W] * r_b[(k*DIM+c)*ELEM_W +: ELEM_W];
        end
        w_mult[(r*DIM+c)*ELEM_W +: ELEM_W] = w_sum;
      end
    end
  end

  always_comb begin
    w_acc_next = '0;
    for (int i = 0; i < DIM*DIM; i++) begin
      w_acc_next[i*ELEM_W +: ELEM_W] = accAdd(r_acc[i*ELEM_W +: ELEM_W], w_mult[i*ELEM_W +: ELEM_W]);
    end
  end

  assign w_acc_pulse = acc_en & ~r_acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_q <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_acc_q <= acc_en;
      if (clear) begin
        r_acc <= '0;
      end else if (w_acc_pulse) begin
        r_acc <= w_acc_next;
      end
    end
  end

  assign word_done  = w_word_done;
  assign pair_ready = r_pair_ready;
  assign mult_out   = w_mult;
  assign acc_out    = r_acc;

endmodule

// File: tb/tb_tpu_mac_core.sv
// Directed self-checking bench for tpu_mac_core with hand-computed vectors.
module tb_tpu_mac_core;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        write_en;
  logic        acc_en;
  logic        clear;
  logic        word_done;
  logic        pair_ready;
  logic [63:0] mult_out;
  logic [63:0] acc_out;

  int testsRun  = 0;
  int testsFail = 0;
  int wdCount   = 0;
  int prCount   = 0;
  int wdBefore;
  int prBefore;

`ifdef TPU_ACC_SAT_EN
  localparam logic [63:0] WRAP_EXP = 64'h0000_0000_0000_FFFF;
`else
  localparam logic [63:0] WRAP_EXP = 64'h0000_0000_0000_FFFE;
`endif

  tpu_mac_core dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .write_en  (write_en),
    .acc_en    (acc_en),
    .clear     (clear),
    .word_done (word_done),
    .pair_ready(pair_ready),
    .mult_out  (mult_out),
    .acc_out   (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (word_done)  wdCount++;
    if (pair_ready) prCount++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    data_in  = b;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic sendWord(input logic [63:0] w);
    for (int i = 7; i >= 0; i--) sendByte(w[i*8 +: 8]);
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b);
    sendWord(a);
    sendWord(b);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulseAcc();
    @(negedge clk);
    acc_en = 1'b1;
    @(negedge clk);
    acc_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b0;
    data_in  = 8'h00;
    write_en = 1'b0;
    acc_en   = 1'b0;
    clear    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_mult", mult_out, 64'h0);
    checkOutput("reset_acc", acc_out, 64'h0);
    checkOutput("reset_flags", {62'h0, word_done, pair_ready}, 64'h0);
    rst = 1'b1;

    // Three stale bytes, then reset mid-word.
    sendByte(8'hFF);
    sendByte(8'hFF);
    sendByte(8'hFF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_mult", mult_out, 64'h0);
    checkOutput("midreset_acc", acc_out, 64'h0);

    wdBefore = wdCount;
    prBefore = prCount;
    sendWord(64'h0004_0003_0002_0001);
    repeat (3) @(negedge clk);
    checkOutput("a_word_done", 64'(wdCount - wdBefore), 64'd1);
    checkOutput("a_no_pair", 64'(prCount - prBefore), 64'd0);
    sendWord(64'h0008_0007_0006_0005);
    repeat (3) @(negedge clk);
    checkOutput("b_pair_ready", 64'(prCount - prBefore), 64'd1);
    checkOutput("b_word_done", 64'(wdCount - wdBefore), 64'd2);
    checkOutput("mult_basic", mult_out, 64'h0032_002B_0016_0013);

    pulseAcc();
    checkOutput("acc_once", acc_out, 64'h0032_002B_0016_0013);
    pulseAcc();
    checkOutput("acc_twice", acc_out, 64'h0064_0056_002C_0026);

    @(negedge clk);
    acc_en = 1'b1;
    repeat (10) @(negedge clk);
    acc_en = 1'b0;
    @(negedge clk);
    checkOutput("acc_hold", acc_out, 64'h0096_0081_0042_0039);

    @(negedge clk);
    clear  = 1'b1;
    acc_en = 1'b1;
    @(negedge clk);
    clear  = 1'b0;
    acc_en = 1'b0;
    @(negedge clk);
    checkOutput("clear_priority", acc_out, 64'h0);
    pulseAcc();
    checkOutput("acc_after_clear", acc_out, 64'h0032_002B_0016_0013);

    applyStimulus(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0002);
    checkOutput("mult_truncate", mult_out, 64'h0000_0000_0000_FFFE);
    checkOutput("acc_kept_on_load", acc_out, 64'h0032_002B_0016_0013);

    applyStimulus(64'h0000_0000_0000_FFFF, 64'h0001_0000_0000_0001);
    checkOutput("mult_identity", mult_out, 64'h0000_0000_0000_FFFF);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    pulseAcc();
    pulseAcc();
    checkOutput("acc_wrap_sat", acc_out, WRAP_EXP);

    // Held strobe with changing data captures only the first byte.
    wdBefore = wdCount;
    @(negedge clk);
    data_in  = 8'h11;
    write_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data_in = 8'h22 + 8'(i * 17);
    end
    write_en = 1'b0;
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h02);
    sendByte(8'h00);
    sendByte(8'h03);
    sendByte(8'h00);
    repeat (2) @(negedge clk);
    checkOutput("hold_seven_bytes", 64'(wdCount - wdBefore), 64'd0);
    sendByte(8'h04);
    repeat (3) @(negedge clk);
    checkOutput("hold_eight_bytes", 64'(wdCount - wdBefore), 64'd1);
    checkOutput("hold_word", mult_out, 64'h1100_0002_0003_0004);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
